// File: rtl/lab7_pkg.sv
// Shared definitions for the lab 7 serial pattern transmitter:
// FSM state encoding and the default widths of the datapath.
package lab7_pkg;

  // Default widths; LEN_W must be able to hold W itself, i.e. $clog2(W+1).
  localparam int DEF_W     = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_GAP_W = 4;
  localparam int DEF_REP_W = 4;

  // Encoding is visible on out_state, so the values are fixed explicitly.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage : lab7_pkg

// File: rtl/seq_pattern_tx_if.sv
// Request/response bundle of the pattern transmitter. The master side
// (stimulus controller or bench) drives the request; the transmitter
// is the slave and returns the serial stream plus status.
interface seq_pattern_tx_if
  import lab7_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int GAP_W = DEF_GAP_W,
  parameter int REP_W = DEF_REP_W
);

  // Request side
  logic             start;
  logic [W-1:0]     pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] rep;
  logic [GAP_W-1:0] gap;

  // Response side
  logic             out;
  logic             valid;
  logic             busy;
  logic             done;
  logic [1:0]       out_state;

  modport master (
    output start, pattern, len, rep, gap,
    input  out, valid, busy, done, out_state
  );

  modport slave (
    input  start, pattern, len, rep, gap,
    output out, valid, busy, done, out_state
  );

endinterface : seq_pattern_tx_if

// File: rtl/seq_pattern_tx_down_counter.sv
// Loadable down counter with a zero flag. Load wins over enable, and the
// count saturates at zero instead of wrapping, so a caller that keeps
// enable high past the end simply sees zero_o stay asserted.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  // Count register: synchronous clear, load, or saturating decrement.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of the order blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule : down_counter

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter. A request latched in IDLE is shifted out
// MSB-first (bit len-1 first), repeated rep+1 times with gap idle cycles
// between repetitions, and closed by a one-cycle DONE. All outputs come
// straight from flops, so a downstream detector sees clean edges.
module seq_pattern_tx
  import lab7_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int GAP_W = DEF_GAP_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic            clk,
  input  logic            rst,
  seq_pattern_tx_if.slave bus
);

  // ---------------------------------------------------------------------
  // State, shadow copies of the request, output flops
  // ---------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [W-1:0]     pat_q,   pat_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [GAP_W-1:0] gap_q,   gap_d;

  logic out_q,   out_d;
  logic valid_q, valid_d;
  logic busy_q,  busy_d;
  logic done_q,  done_d;

  // Counter controls
  logic             idx_load, idx_en, idx_zero;
  logic [LEN_W-1:0] idx_load_val, idx_cnt, idx_next;
  logic             gap_load, gap_en, gap_zero;
  logic [GAP_W-1:0] gap_load_val, gap_cnt;
  logic             rep_load, rep_en, rep_zero;
  logic [REP_W-1:0] rep_cnt;

  logic             accept;
  logic [LEN_W-1:0] len_eff;

  // Select one pattern bit by a LEN_W-wide index without a width-mismatched
  // bit-select; indices at or above W read as 0.
  function automatic logic bit_at(input logic [W-1:0] p, input logic [LEN_W-1:0] i);
    logic b;
    b = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (i == LEN_W'(k)) b = p[k];
    end
    return b;
  endfunction

  // Oversized lengths are clamped so the index never points past the pattern.
  assign len_eff = (bus.len > LEN_W'(W)) ? LEN_W'(W) : bus.len;
  assign accept  = (state_q == IDLE) && bus.start && (bus.len != '0);

  // ---------------------------------------------------------------------
  // Counters: bit index, gap length, remaining repetitions
  // ---------------------------------------------------------------------
  down_counter #(.WIDTH(LEN_W)) u_idx_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (idx_load),
    .en_i       (idx_en),
    .load_val_i (idx_load_val),
    .count_o    (idx_cnt),
    .zero_o     (idx_zero)
  );

  down_counter #(.WIDTH(GAP_W)) u_gap_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gap_load),
    .en_i       (gap_en),
    .load_val_i (gap_load_val),
    .count_o    (gap_cnt),
    .zero_o     (gap_zero)
  );

  down_counter #(.WIDTH(REP_W)) u_rep_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (rep_load),
    .en_i       (rep_en),
    .load_val_i (bus.rep),
    .count_o    (rep_cnt),
    .zero_o     (rep_zero)
  );

  // State register, shadow registers and output flops.
  // NOTE: the shadow registers are cleared on reset too; they are a handful
  // of flops, not a memory array, so the clear costs nothing and keeps the
  // post-reset state fully defined.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counter control. The gap counter is loaded with gap-1
  // and left on zero, which gives exactly gap cycles in GAP.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    len_d        = len_q;
    gap_d        = gap_q;
    idx_load     = 1'b0;
    idx_load_val = len_q - LEN_W'(1);
    idx_en       = (state_q == SHIFT);
    gap_load     = 1'b0;
    gap_load_val = gap_q - GAP_W'(1);
    gap_en       = 1'b0;
    rep_load     = 1'b0;
    rep_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = SHIFT;
          pat_d        = bus.pattern;
          len_d        = len_eff;
          gap_d        = bus.gap;
          idx_load     = 1'b1;
          idx_load_val = len_eff - LEN_W'(1);
          rep_load     = 1'b1;
        end
      end
      SHIFT: begin
        if (idx_zero) begin
          if (rep_zero) begin
            state_d = DONE;
          end else begin
            rep_en = 1'b1;
            if (gap_q == '0) begin
              // Back-to-back repetition: reload the index, no bubble.
              idx_load = 1'b1;
            end else begin
              state_d  = GAP;
              gap_load = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (gap_zero) begin
          state_d  = SHIFT;
          idx_load = 1'b1;
        end else begin
          gap_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Index the counter will hold after this edge; mirrors down_counter.
  assign idx_next = idx_load ? idx_load_val :
                    (idx_en && !idx_zero) ? (idx_cnt - LEN_W'(1)) : idx_cnt;

  // Output values for the next cycle, derived from the next state so the
  // registered outputs line up with state_q.
  always_comb begin
    out_d   = (state_d == SHIFT) && bit_at(pat_d, idx_next);
    valid_d = (state_d == SHIFT);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  assign bus.out       = out_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_state = state_q;

endmodule : seq_pattern_tx

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: a per-cycle vector table for reset,
// single sends, aborts, ignored requests and length clamping, followed by
// hand-written multi-cycle sequences and run-length measurements.
module tb_seq_pattern_tx;

  logic clk;
  logic rst;

  seq_pattern_tx_if bus ();

  seq_pattern_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] rep;
    logic [3:0] gap;
    logic       e_out;
    logic       e_valid;
    logic       e_busy;
    logic       e_done;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic [7:0] p,
                              input logic [3:0] l, input logic [3:0] rp, input logic [3:0] g,
                              input logic eo, input logic ev, input logic eb,
                              input logic ed, input logic [1:0] es);
    vec_t v;
    v.rst = r; v.start = s; v.pattern = p; v.len = l; v.rep = rp; v.gap = g;
    v.e_out = eo; v.e_valid = ev; v.e_busy = eb; v.e_done = ed; v.e_st = es;
    return v;
  endfunction

  // Wait one edge, then compare all outputs on the following falling edge.
  task automatic step(input string name, input logic eo, input logic ev,
                      input logic eb, input logic ed, input logic [1:0] es);
    @(posedge clk);
    @(negedge clk);
    check({name, ".out"},   32'(bus.out),       32'(eo));
    check({name, ".valid"}, 32'(bus.valid),     32'(ev));
    check({name, ".busy"},  32'(bus.busy),      32'(eb));
    check({name, ".done"},  32'(bus.done),      32'(ed));
    check({name, ".state"}, 32'(bus.out_state), 32'(es));
  endtask

  // Issue one request and observe the whole transaction, with a bounded wait.
  // A simple 1011 detector on the valid bits stands in for the lab detector.
  task automatic measure(input string name, input logic [7:0] p, input logic [3:0] l,
                         input logic [3:0] rp, input logic [3:0] g,
                         input int e_busy, input int e_valid, input int e_z, input int e_zfirst);
    int busy_cyc, valid_cyc, done_cnt, z_cnt, z_first, bitn;
    logic [3:0] sh;
    logic finished;
    busy_cyc = 0; valid_cyc = 0; done_cnt = 0; z_cnt = 0; z_first = -1; bitn = 0;
    sh = 4'b0; finished = 1'b0;
    bus.start = 1'b1; bus.pattern = p; bus.len = l; bus.rep = rp; bus.gap = g;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bus.busy) begin
        finished = 1'b1;
        break;
      end
      busy_cyc++;
      if (bus.done) done_cnt++;
      if (bus.valid) begin
        valid_cyc++;
        bitn++;
        sh = {sh[2:0], bus.out};
        if (bitn >= 4 && sh == 4'b1011) begin
          z_cnt++;
          if (z_first < 0) z_first = bitn;
        end
      end
    end
    check({name, ".finished"}, 32'(finished), 32'd1);
    check({name, ".busy_cycles"}, busy_cyc, e_busy);
    check({name, ".valid_cycles"}, valid_cyc, e_valid);
    check({name, ".done_pulses"}, done_cnt, 32'd1);
    if (e_z >= 0) begin
      check({name, ".z_count"}, z_cnt, e_z);
      check({name, ".z_first_bit"}, z_first, e_zfirst);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.pattern = '0; bus.len = '0; bus.rep = '0; bus.gap = '0;

    // Reset, then idle
    vecs.push_back(mk(1, 0, 8'h00, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 0, 8'h00, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 2'd0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 8'h00, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 2'd0));
    // 1011, len 4, single send; inputs scrambled mid-send; start during DONE ignored
    vecs.push_back(mk(0, 1, 8'h0B, 4'd4, 4'd0, 4'd0, 1, 1, 1, 0, 2'd1));
    vecs.push_back(mk(0, 1, 8'hF4, 4'd1, 4'd5, 4'd3, 0, 1, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 8'hF4, 4'd1, 4'd5, 4'd3, 1, 1, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 8'h0B, 4'd4, 4'd0, 4'd0, 1, 1, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 8'h0B, 4'd4, 4'd0, 4'd0, 0, 0, 1, 1, 2'd3));
    vecs.push_back(mk(0, 1, 8'h0B, 4'd4, 4'd0, 4'd0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 0, 8'h0B, 4'd4, 4'd0, 4'd0, 0, 0, 0, 0, 2'd0));
    // len=0 request ignored
    vecs.push_back(mk(0, 1, 8'hFF, 4'd0, 4'd3, 4'd3, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 1, 8'hFF, 4'd0, 4'd3, 4'd3, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 0, 8'hFF, 4'd0, 4'd3, 4'd3, 0, 0, 0, 0, 2'd0));
    // Reset overrides start
    vecs.push_back(mk(1, 1, 8'h0B, 4'd4, 4'd0, 4'd0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 0, 8'h0B, 4'd4, 4'd0, 4'd0, 0, 0, 0, 0, 2'd0));
    // Abort during second bit, no done, then a fresh full send
    vecs.push_back(mk(0, 1, 8'h0B, 4'd4, 4'd0, 4'd0, 1, 1, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 8'h0B, 4'd4, 4'd0, 4'd0, 0, 1, 1, 0, 2'd1));
    vecs.push_back(mk(1, 0, 8'h0B, 4'd4, 4'd0, 4'd0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 0, 8'h0B, 4'd4, 4'd0, 4'd0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 0, 8'h0B, 4'd4, 4'd0, 4'd0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 1, 8'h0B, 4'd4, 4'd0, 4'd0, 1, 1, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 8'h0B, 4'd4, 4'd0, 4'd0, 0, 1, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 8'h0B, 4'd4, 4'd0, 4'd0, 1, 1, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 8'h0B, 4'd4, 4'd0, 4'd0, 1, 1, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 8'h0B, 4'd4, 4'd0, 4'd0, 0, 0, 1, 1, 2'd3));
    vecs.push_back(mk(0, 0, 8'h0B, 4'd4, 4'd0, 4'd0, 0, 0, 0, 0, 2'd0));
    // len=15 clamps to 8: 1000_0001 sent in full
    vecs.push_back(mk(0, 1, 8'h81, 4'd15, 4'd0, 4'd0, 1, 1, 1, 0, 2'd1));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 8'h81, 4'd15, 4'd0, 4'd0, 0, 1, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 8'h81, 4'd15, 4'd0, 4'd0, 1, 1, 1, 0, 2'd1));
    vecs.push_back(mk(0, 0, 8'h81, 4'd15, 4'd0, 4'd0, 0, 0, 1, 1, 2'd3));
    vecs.push_back(mk(0, 0, 8'h81, 4'd15, 4'd0, 4'd0, 0, 0, 0, 0, 2'd0));

    @(negedge clk);
    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      bus.start = vecs[i].start;
      bus.pattern = vecs[i].pattern;
      bus.len   = vecs[i].len;
      bus.rep   = vecs[i].rep;
      bus.gap   = vecs[i].gap;
      step($sformatf("v%0d", i), vecs[i].e_out, vecs[i].e_valid,
           vecs[i].e_busy, vecs[i].e_done, vecs[i].e_st);
    end
    rst = 1'b0;

    // 011, len 3, rep 1, gap 2: 0,1,1, gap, gap, 0,1,1, done
    bus.start = 1'b1; bus.pattern = 8'h03; bus.len = 4'd3; bus.rep = 4'd1; bus.gap = 4'd2;
    step("s3c0", 0, 1, 1, 0, 2'd1);
    bus.start = 1'b0;
    step("s3c1", 1, 1, 1, 0, 2'd1);
    step("s3c2", 1, 1, 1, 0, 2'd1);
    step("s3c3", 0, 0, 1, 0, 2'd2);
    step("s3c4", 0, 0, 1, 0, 2'd2);
    step("s3c5", 0, 1, 1, 0, 2'd1);
    step("s3c6", 1, 1, 1, 0, 2'd1);
    step("s3c7", 1, 1, 1, 0, 2'd1);
    step("s3c8", 0, 0, 1, 1, 2'd3);
    step("s3c9", 0, 0, 0, 0, 2'd0);

    // 10, len 2, rep 2, gap 0: back-to-back; pattern changed mid-send
    bus.start = 1'b1; bus.pattern = 8'h02; bus.len = 4'd2; bus.rep = 4'd2; bus.gap = 4'd0;
    step("s4c0", 1, 1, 1, 0, 2'd1);
    bus.start = 1'b0; bus.pattern = 8'h01;
    step("s4c1", 0, 1, 1, 0, 2'd1);
    step("s4c2", 1, 1, 1, 0, 2'd1);
    step("s4c3", 0, 1, 1, 0, 2'd1);
    step("s4c4", 1, 1, 1, 0, 2'd1);
    step("s4c5", 0, 1, 1, 0, 2'd1);
    step("s4c6", 0, 0, 1, 1, 2'd3);
    step("s4c7", 0, 0, 0, 0, 2'd0);

    // Run-length measurements: (R+1)*L + R*G + 1 busy cycles
    measure("m_s3",     8'h03, 4'd3, 4'd1,  4'd2,  9,  6, -1, 0);
    measure("m_repmax", 8'h01, 4'd1, 4'd15, 4'd0,  17, 16, -1, 0);
    measure("m_gapmax", 8'h01, 4'd1, 4'd1,  4'd15, 18, 2,  -1, 0);
    // Closed loop: 1011 twice back-to-back, detector fires on bits 4 and 8
    measure("m_loop",   8'h0B, 4'd4, 4'd1,  4'd0,  9,  8,  2,  4);
    // Same with a gap: idle cycles carry no bits, so detection is unchanged
    measure("m_loopg",  8'h0B, 4'd4, 4'd1,  4'd3,  12, 8,  2,  4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_pattern_tx
